// File: rtl/cp_mod_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cp_mod_addsub : two-stage pipelined (a+b) mod P / (a-b) mod P            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cp_mod_addsub #(
  parameter int          DW = 22,
  parameter int unsigned P  = 3145729
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] sum_out,
  output logic [DW-1:0] diff_out,
  input  logic          err_clr,
  output logic          range_err
);

  localparam logic [DW:0]   PW = (DW+1)'(P);
  localparam logic [DW-1:0] PL = DW'(P);

  logic          s1_valid;
  logic          s2_valid;
  logic [DW:0]   s1_sum;
  logic [DW:0]   s1_dif;
  logic [DW-1:0] sum_fix;
  logic [DW-1:0] diff_fix;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic          bad_opnd;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = s2_valid;
  assign bad_opnd  = ({1'b0, a_in} >= PW) || ({1'b0, b_in} >= PW);

  // The decision uses the full DW+1-bit value; the correction itself only
  // needs the low DW bits because the result is truncated to DW bits anyway.
  always_comb begin
    sum_fix  = s1_sum[DW-1:0];
    diff_fix = s1_dif[DW-1:0];
    if (s1_sum >= PW) sum_fix  = s1_sum[DW-1:0] - PL;
    if (s1_dif[DW])   diff_fix = s1_dif[DW-1:0] + PL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_dif   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= {1'b0, a_in} + {1'b0, b_in};
        s1_dif <= {1'b0, a_in} - {1'b0, b_in};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum_out  <= '0;
      diff_out <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum_out  <= sum_fix;
        diff_out <= diff_fix;
      end
    end
  end

  // Set has priority over clear so a fresh error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  range_err <= 1'b0;
    else if (accept && bad_opnd) range_err <= 1'b1;
    else if (err_clr)            range_err <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_cp_mod_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cp_mod_addsub : directed bench for cp_mod_addsub                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cp_mod_addsub;

  localparam int    DW = 22;
  localparam longint P = 3145729;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum_out;
  logic [DW-1:0] diff_out;
  logic          err_clr;
  logic          range_err;

  int total = 0;
  int bad   = 0;

  longint a_arr [100];
  longint b_arr [100];

  cp_mod_addsub #(.DW(DW), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .diff_out  (diff_out),
    .err_clr   (err_clr),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum_out, 0);
    check("rst_diff", diff_out, 0);
    check("rst_range_err", range_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // 1: wrap of sum to zero, two-cycle latency
    tick();
    in_valid = 1'b1; a_in = 22'd3145728; b_in = 22'd1;
    #1 check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t1_lat_early", out_valid, 0);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_sum", sum_out, 0);
    check("t1_diff", diff_out, 3145727);

    // 2: borrow correction and maximum operands, back to back
    in_valid = 1'b1; a_in = 22'd0; b_in = 22'd1;
    tick();
    a_in = 22'd3145728; b_in = 22'd3145728;
    check("t2_drain", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t2a_valid", out_valid, 1);
    check("t2a_sum", sum_out, 1);
    check("t2a_diff", diff_out, 3145728);
    tick();
    check("t2b_valid", out_valid, 1);
    check("t2b_sum", sum_out, 3145727);
    check("t2b_diff", diff_out, 0);
    tick();
    check("t2_empty", out_valid, 0);

    // 3: back-pressure, two items held, third waits
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 22'd1; b_in = 22'd2;
    tick();
    a_in = 22'd3; b_in = 22'd4;
    #1 check("t3_ready_2nd", in_ready, 1);
    tick();
    a_in = 22'd5; b_in = 22'd6;
    #1 check("t3_ready_full", in_ready, 0);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_sum0", sum_out, 3);
    tick();
    check("t3_hold_sum1", sum_out, 3);
    check("t3_hold_diff", diff_out, P - 1);
    out_ready = 1'b1;
    #1 check("t3_ready_rel", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_v7", out_valid, 1);
    check("t3_sum7", sum_out, 7);
    tick();
    check("t3_v11", out_valid, 1);
    check("t3_sum11", sum_out, 11);
    tick();
    check("t3_empty", out_valid, 0);

    // 4: full-rate stream against a mod-P model
    for (int i = 0; i < 100; i++) begin
      a_arr[i] = longint'($urandom_range(0, 3145728));
      b_arr[i] = longint'($urandom_range(0, 3145728));
    end
    a_arr[0] = 0;       b_arr[0] = 0;
    a_arr[1] = P - 1;   b_arr[1] = P - 1;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        a_in = DW'(a_arr[i]);
        b_in = DW'(b_arr[i]);
        #1 check("t4_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check("t4_valid", out_valid, 1);
        check("t4_sum", sum_out, (a_arr[i-1] + b_arr[i-1]) % P);
        check("t4_diff", diff_out, (a_arr[i-1] + P - b_arr[i-1]) % P);
      end
    end
    tick();
    check("t4_empty", out_valid, 0);

    // 5: sticky range error, clear, set-wins, idle beats ignored
    check("t5_clean", range_err, 0);
    in_valid = 1'b1; a_in = 22'd3145729; b_in = 22'd0;
    tick();
    in_valid = 1'b0;
    check("t5_set", range_err, 1);
    tick(); tick(); tick();
    check("t5_sticky", range_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_clear", range_err, 0);
    a_in = 22'd3145729; b_in = 22'd3145730;
    tick();
    check("t5_idle_bad", range_err, 0);
    err_clr = 1'b1; in_valid = 1'b1; a_in = 22'd5; b_in = 22'd3145730;
    tick();
    err_clr = 1'b0; in_valid = 1'b0;
    check("t5_set_wins", range_err, 1);
    tick(); tick();
    check("t5_drained", out_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 6: asynchronous reset with two items in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 22'd1; b_in = 22'd1;
    tick();
    a_in = 22'd2; b_in = 22'd2;
    tick();
    in_valid = 1'b0;
    check("t6_full_valid", out_valid, 1);
    check("t6_full_sum", sum_out, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_sum", sum_out, 0);
    check("t6_rst_diff", diff_out, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_stale", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
